// File: rtl/secure_tx_channel_pkg.sv
// Shared types and helpers for the secure transmit channel.
// Holds the FSM state encoding, derived-size helpers and the tweak formatter.
package secure_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XMIT = 2'd1,
        ST_ZERO = 2'd2
    } state_e;

    localparam int unsigned TW_MAX = 128;

    function automatic int unsigned beats(input int unsigned data_w, input int unsigned word_w);
        return data_w / word_w;
    endfunction

    function automatic int unsigned key_words(input int unsigned key_w, input int unsigned word_w);
        return key_w / word_w;
    endfunction

    function automatic int unsigned ctr_w(input int unsigned word_w);
        return word_w / 2;
    endfunction

    // Tweak word {frame_ctr, beat}; the caller truncates to WORD_W.
    function automatic logic [TW_MAX-1:0] tweak(input logic [TW_MAX-1:0] ctr,
                                                input logic [TW_MAX-1:0] beat,
                                                input int unsigned       cw);
        logic [TW_MAX-1:0] mask;
        mask = (TW_MAX'(1) << cw) - TW_MAX'(1);
        return (ctr << cw) | (beat & mask);
    endfunction

endpackage

// File: rtl/secure_tx_channel_if.sv
// Plaintext-in / ciphertext-out valid/ready streams of the secure transmit channel.
// master = producer/consumer side, slave = channel side.
interface secure_tx_channel_if #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned WORD_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/secure_tx_channel_keystream.sv
// Combinational keystream: selected key word XOR {frame_ctr, beat} tweak.
module secure_tx_keystream
    import secure_tx_pkg::*;
#(
    parameter int unsigned KEY_W  = 128,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned IDX_W  = 3,
    parameter int unsigned CTR_W  = 16
) (
    input  logic [KEY_W-1:0]  key_i,
    input  logic [IDX_W-1:0]  beat_i,
    input  logic [CTR_W-1:0]  ctr_i,
    output logic [WORD_W-1:0] ks_c
);
    localparam int unsigned KEY_WORDS = key_words(KEY_W, WORD_W);

    int unsigned kidx;

    always_comb begin
        kidx = 32'(beat_i) % KEY_WORDS;
        ks_c = key_i[kidx*WORD_W +: WORD_W]
             ^ WORD_W'(tweak(TW_MAX'(ctr_i), TW_MAX'(beat_i), CTR_W));
    end
endmodule

// File: rtl/secure_tx_channel.sv
// Secure transmit channel: accepts a plaintext frame, streams it out as
// key/tweak-masked WORD_W beats, then zeroizes the plaintext buffer.
module secure_tx_channel
    import secure_tx_pkg::*;
#(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned KEY_W  = 128,
    parameter int unsigned WORD_W = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [KEY_W-1:0]              key_in,
    input  logic                          key_load,
    input  logic                          key_clear,
    output logic                          key_valid,
    secure_tx_channel_if.slave            bus,
    output logic [ctr_w(WORD_W)-1:0]      frame_ctr,
    output logic                          abort
);
    localparam int unsigned BEATS = beats(DATA_W, WORD_W);
    localparam int unsigned CTR_W = ctr_w(WORD_W);
    localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_e            state_q;
    logic [KEY_W-1:0]  key_q;
    logic              key_valid_q;
    logic [DATA_W-1:0] payload_q;
    logic [IDX_W-1:0]  beat_q;
    logic [CTR_W-1:0]  frame_ctr_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [WORD_W-1:0] out_data_q;
    logic              out_last_q;
    logic              abort_q;

    logic [IDX_W-1:0]  beat_d;
    logic [WORD_W-1:0] pt_word_c;
    logic [WORD_W-1:0] ks_c;
    logic              accept_c;

    // Beat about to be presented: 0 on accept, beat+1 while streaming.
    always_comb begin
        beat_d    = '0;
        pt_word_c = bus.in_data[WORD_W-1:0];
        accept_c  = (state_q == ST_IDLE) && bus.in_valid && in_ready_q;
        if (state_q == ST_XMIT && beat_q != IDX_W'(BEATS-1)) begin
            beat_d    = beat_q + IDX_W'(1);
            pt_word_c = payload_q[32'(beat_d)*WORD_W +: WORD_W];
        end
    end

    secure_tx_keystream #(
        .KEY_W  (KEY_W),
        .WORD_W (WORD_W),
        .IDX_W  (IDX_W),
        .CTR_W  (CTR_W)
    ) u_keystream (
        .key_i  (key_q),
        .beat_i (beat_d),
        .ctr_i  (frame_ctr_q),
        .ks_c   (ks_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            payload_q   <= '0;
            beat_q      <= '0;
            frame_ctr_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A key loaded alongside an accept only affects later frames.
                    if (key_load) begin
                        key_q       <= key_in;
                        key_valid_q <= 1'b1;
                    end
                    if (accept_c) begin
                        payload_q   <= bus.in_data;
                        beat_q      <= '0;
                        state_q     <= ST_XMIT;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= pt_word_c ^ ks_c;
                        out_last_q  <= 1'(BEATS == 1);
                    end else begin
                        in_ready_q  <= key_valid_q | key_load;
                    end
                end
                ST_XMIT: begin
                    if (out_valid_q && bus.out_ready) begin
                        if (out_last_q) begin
                            state_q     <= ST_ZERO;
                            out_valid_q <= 1'b0;
                            out_data_q  <= '0;
                            out_last_q  <= 1'b0;
                        end else begin
                            beat_q      <= beat_d;
                            out_data_q  <= pt_word_c ^ ks_c;
                            out_last_q  <= (beat_d == IDX_W'(BEATS-1));
                        end
                    end
                end
                ST_ZERO: begin
                    payload_q   <= '0;
                    beat_q      <= '0;
                    frame_ctr_q <= frame_ctr_q + CTR_W'(1);
                    state_q     <= ST_IDLE;
                    in_ready_q  <= key_valid_q;
                end
                default: state_q <= ST_IDLE;
            endcase

            // Zeroize the key; an in-flight (or just-accepted) frame is abandoned.
            if (key_clear) begin
                key_q       <= '0;
                key_valid_q <= 1'b0;
                in_ready_q  <= 1'b0;
                if (state_q == ST_XMIT || accept_c) begin
                    state_q     <= ST_ZERO;
                    out_valid_q <= 1'b0;
                    out_data_q  <= '0;
                    out_last_q  <= 1'b0;
                    abort_q     <= 1'b1;
                end
            end
        end
    end

    assign key_valid     = key_valid_q;
    assign frame_ctr     = frame_ctr_q;
    assign abort         = abort_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_secure_tx_channel.sv
// Directed self-checking bench for secure_tx_channel (DATA_W=256, KEY_W=128, WORD_W=32).
module tb_secure_tx_channel;
    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] key_in;
    logic         key_load;
    logic         key_clear;
    logic         key_valid;
    logic [15:0]  frame_ctr;
    logic         abort;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] KEY_A = 128'h00000004_00000003_00000002_00000001;

    logic [31:0] exp1 [8] = '{32'h00000001, 32'h00000003, 32'h00000001, 32'h00000007,
                              32'h00000005, 32'h00000007, 32'h00000005, 32'h00000003};
    logic [31:0] exp_w [8];

    always #5 clk = ~clk;

    secure_tx_channel_if #(.DATA_W(256), .WORD_W(32)) bus ();

    secure_tx_channel #(.DATA_W(256), .KEY_W(128), .WORD_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_in    (key_in),
        .key_load  (key_load),
        .key_clear (key_clear),
        .key_valid (key_valid),
        .bus       (bus),
        .frame_ctr (frame_ctr),
        .abort     (abort)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference beat: plaintext word ^ key word[b mod 4] ^ {ctr, b}.
    task automatic build_exp(input logic [255:0] pt, input logic [127:0] key,
                             input logic [15:0] ctr, output logic [31:0] e [8]);
        for (int b = 0; b < 8; b++)
            e[b] = pt[b*32 +: 32] ^ key[(b%4)*32 +: 32] ^ {ctr, 16'(b)};
    endtask

    task automatic load_key(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        chk("key_valid_after_load", 64'(key_valid), 64'(1));
    endtask

    task automatic start_frame(input logic [255:0] d, input string tag);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !bus.in_ready; i++) step();
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    // Receive n beats; with bp, out_ready follows 1,0,0,1,0,0,...
    task automatic recv_beats(input logic [31:0] e [8], input int n, input bit bp, input string tag);
        int b   = 0;
        int cyc = 0;
        while (b < n && cyc < 200) begin
            bus.out_ready = bp ? ((cyc % 3) == 0) : 1'b1;
            chk({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
            if (bus.out_valid) begin
                chk({tag, "_data"}, 64'(bus.out_data), 64'(e[b]));
                chk({tag, "_last"}, 64'(bus.out_last), 64'(b == 7));
                if (bus.out_ready) b++;
            end
            step();
            cyc++;
        end
        bus.out_ready = 1'b0;
        chk({tag, "_beats_done"}, 64'(b), 64'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        key_in        = '0;
        key_load      = 1'b0;
        key_clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_key_valid", 64'(key_valid), 64'(0));
        chk("rst_outs", 64'({bus.in_ready, bus.out_valid, bus.out_last, abort}), 64'(0));
        chk("rst_out_data", 64'(bus.out_data), 64'(0));
        chk("rst_frame_ctr", 64'(frame_ctr), 64'(0));
        reset = 1'b0;
        step();

        // No key: frames must be refused.
        bus.in_valid = 1'b1;
        bus.in_data  = {8{32'hDEADBEEF}};
        for (int i = 0; i < 20; i++) begin
            chk("nokey_refused", 64'({bus.in_ready, bus.out_valid}), 64'(0));
            step();
        end
        bus.in_valid = 1'b0;

        // Frame 1: zero plaintext, known key.
        load_key(KEY_A);
        chk("in_ready_after_load", 64'(bus.in_ready), 64'(1));
        start_frame('0, "f1");
        recv_beats(exp1, 8, 1'b0, "f1");
        chk("f1_zero_state", 64'({bus.out_valid, bus.in_ready}), 64'(0));
        step();
        chk("f1_in_ready_back", 64'(bus.in_ready), 64'(1));
        chk("f1_frame_ctr", 64'(frame_ctr), 64'(1));

        // Frame 2: same key/data, frame_ctr=1 lands in the upper half.
        for (int i = 0; i < 8; i++) exp_w[i] = exp1[i] ^ 32'h00010000;
        chk("f2_beat0_hand", 64'(exp_w[0]), 64'(32'h00010001));
        start_frame('0, "f2");
        recv_beats(exp_w, 8, 1'b0, "f2");
        step();
        chk("f2_frame_ctr", 64'(frame_ctr), 64'(2));

        // Frame 3: plaintext word0 all-ones, under backpressure.
        build_exp({224'h0, 32'hFFFFFFFF}, KEY_A, 16'h0002, exp_w);
        chk("f3_beat0_hand", 64'(exp_w[0]), 64'(32'hFFFDFFFE));
        start_frame({224'h0, 32'hFFFFFFFF}, "f3");
        recv_beats(exp_w, 8, 1'b1, "f3bp");
        step();
        chk("f3_frame_ctr", 64'(frame_ctr), 64'(3));

        // Frame 4: key_clear while beat 3 is presented.
        build_exp({8{32'h12345678}}, KEY_A, 16'h0003, exp_w);
        start_frame({8{32'h12345678}}, "f4");
        recv_beats(exp_w, 3, 1'b0, "f4");
        chk("f4_beat3_data", 64'(bus.out_data), 64'(exp_w[3]));
        key_clear = 1'b1;
        step();
        key_clear = 1'b0;
        chk("clr_out_valid", 64'(bus.out_valid), 64'(0));
        chk("clr_out_data", 64'(bus.out_data), 64'(0));
        chk("clr_abort", 64'(abort), 64'(1));
        chk("clr_key_valid", 64'(key_valid), 64'(0));
        step();
        chk("clr_abort_one_shot", 64'(abort), 64'(0));
        chk("clr_frame_ctr", 64'(frame_ctr), 64'(4));
        chk("clr_payload_zero", 64'(dut.payload_q == '0), 64'(1));
        bus.in_valid = 1'b1;
        bus.in_data  = {8{32'hCAFEF00D}};
        for (int i = 0; i < 10; i++) begin
            chk("clr_refused", 64'({bus.in_ready, bus.out_valid}), 64'(0));
            step();
        end
        bus.in_valid = 1'b0;

        // Reset in the middle of a frame.
        load_key(KEY_A);
        build_exp({8{32'h0F0F0F0F}}, KEY_A, 16'h0004, exp_w);
        start_frame({8{32'h0F0F0F0F}}, "f5");
        recv_beats(exp_w, 2, 1'b0, "f5");
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_outs", 64'({bus.in_ready, bus.out_valid, bus.out_last, abort}), 64'(0));
        chk("midrst_out_data", 64'(bus.out_data), 64'(0));
        chk("midrst_key_valid", 64'(key_valid), 64'(0));
        chk("midrst_frame_ctr", 64'(frame_ctr), 64'(0));
        step();

        // Frame counter wrap from 0xFFFF.
        load_key(KEY_A);
        force dut.frame_ctr_q = 16'hFFFF;
        release dut.frame_ctr_q;
        step();
        chk("wrap_ctr_forced", 64'(frame_ctr), 64'(16'hFFFF));
        build_exp({8{32'hA5A5A5A5}}, KEY_A, 16'hFFFF, exp_w);
        start_frame({8{32'hA5A5A5A5}}, "fw");
        recv_beats(exp_w, 8, 1'b0, "fw");
        step();
        chk("wrap_ctr_zero", 64'(frame_ctr), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
